// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32I/M execute unit with registered valid/ready result.
// Divider is built only when ALU_MC_DIV_EN is defined; otherwise div/rem ops return 0 in one cycle.
module alu_mc #(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALUI  = 7'b0010011;
   localparam logic [6:0] OP_ALUR  = 7'b0110011;
   localparam int SW  = $clog2(XLEN);
   localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [MCW-1:0] MUL_LOAD = MCW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_DONE, S_MUL, S_DIV} state_t;
   typedef enum logic [1:0] {C_ONE, C_MUL, C_DIV} cls_t;

   state_t            state, state_nx;
   cls_t              cls;
   logic              accept;
   logic [SW-1:0]     shamt;
   logic [XLEN-1:0]   alu_out, sra_v;
   logic              lt_s, lt_u;

   // Multiplier operands carry an extra sign bit so one signed multiply covers all four variants.
   logic [XLEN:0]          ma_in, mb_in, ma_q, mb_q, ma, mb;
   logic signed [2*XLEN-1:0] ma_w, mb_w, prod;
   logic                   mul_hi_q, mul_hi;
   logic [XLEN-1:0]        mul_res;
   logic [MCW-1:0]         mul_cnt;

   assign shamt = b[SW-1:0];
   assign sra_v = $signed(a) >>> shamt;
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;

   assign ma_in   = {(funct3[1:0] != 2'b11) & a[XLEN-1], a};
   assign mb_in   = {~funct3[1] & b[XLEN-1], b};
   assign ma      = (MUL_LATENCY == 1) ? ma_in : ma_q;
   assign mb      = (MUL_LATENCY == 1) ? mb_in : mb_q;
   assign mul_hi  = (MUL_LATENCY == 1) ? (funct3 != 3'b000) : mul_hi_q;
   assign ma_w    = {{(XLEN-1){ma[XLEN]}}, ma};
   assign mb_w    = {{(XLEN-1){mb[XLEN]}}, mb};
   assign prod    = ma_w * mb_w;
   assign mul_res = mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

   always_comb begin
      alu_out = '0;
      cls     = C_ONE;
      case (op)
         OP_LOAD, OP_STORE: alu_out = a + b;
         OP_ALUI: begin
            case (funct3)
               3'b000: alu_out = a + b;
               3'b010: alu_out = {{(XLEN-1){1'b0}}, lt_s};
               3'b011: alu_out = {{(XLEN-1){1'b0}}, lt_u};
               3'b100: alu_out = a ^ b;
               3'b110: alu_out = a | b;
               3'b111: alu_out = a & b;
               3'b001: alu_out = a << shamt;
               default: alu_out = funct7[5] ? sra_v : (a >> shamt);
            endcase
         end
         OP_ALUR: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: alu_out = a + b;
                  3'b001: alu_out = a << shamt;
                  3'b010: alu_out = {{(XLEN-1){1'b0}}, lt_s};
                  3'b011: alu_out = {{(XLEN-1){1'b0}}, lt_u};
                  3'b100: alu_out = a ^ b;
                  3'b101: alu_out = a >> shamt;
                  3'b110: alu_out = a | b;
                  default: alu_out = a & b;
               endcase
            end else if (funct7 == 7'b0100000) begin
               if (funct3 == 3'b000)
                  alu_out = a - b;
               else if (funct3 == 3'b101)
                  alu_out = sra_v;
            end else if (funct7 == 7'b0000001) begin
               if (!funct3[2]) begin
                  if (MUL_LATENCY == 1)
                     alu_out = mul_res;
                  else
                     cls = C_MUL;
               end
`ifdef ALU_MC_DIV_EN
               else
                  cls = C_DIV;
`endif
            end
         end
         default: alu_out = '0;
      endcase
   end

`ifdef ALU_MC_DIV_EN
   logic [XLEN-1:0] dv_rem, dv_quo, dv_dvs, dv_a;
   logic [SW-1:0]   dv_cnt;
   logic            dv_negq, dv_negr, dv_dz, dv_isrem;
   logic            sgn_a, sgn_b;
   logic [XLEN:0]   dv_shift, dv_trial;
   logic [XLEN-1:0] dv_rem_nx, dv_quo_nx, dv_q_fin, dv_r_fin, dv_out;

   assign sgn_a = ~funct3[0] & a[XLEN-1];
   assign sgn_b = ~funct3[0] & b[XLEN-1];

   // One restoring step: the trial subtraction's top bit tells whether the divisor fits.
   always_comb begin
      dv_shift = {dv_rem, dv_quo[XLEN-1]};
      dv_trial = dv_shift - {1'b0, dv_dvs};
      if (!dv_trial[XLEN]) begin
         dv_rem_nx = dv_trial[XLEN-1:0];
         dv_quo_nx = {dv_quo[XLEN-2:0], 1'b1};
      end else begin
         dv_rem_nx = dv_shift[XLEN-1:0];
         dv_quo_nx = {dv_quo[XLEN-2:0], 1'b0};
      end
      dv_q_fin = dv_dz ? '1   : (dv_negq ? -dv_quo_nx : dv_quo_nx);
      dv_r_fin = dv_dz ? dv_a : (dv_negr ? -dv_rem_nx : dv_rem_nx);
      dv_out   = dv_isrem ? dv_r_fin : dv_q_fin;
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         dv_rem   <= '0;
         dv_quo   <= sgn_a ? -a : a;
         dv_dvs   <= sgn_b ? -b : b;
         dv_cnt   <= SW'(XLEN - 1);
         dv_negq  <= sgn_a ^ sgn_b;
         dv_negr  <= sgn_a;
         dv_dz    <= (b == '0);
         dv_isrem <= funct3[1];
         dv_a     <= a;
      end else if (state == S_DIV) begin
         dv_rem <= dv_rem_nx;
         dv_quo <= dv_quo_nx;
         dv_cnt <= dv_cnt - 1'b1;
      end
   end
`endif

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state)
         S_IDLE:  in_ready = 1'b1;
         S_DONE:  in_ready = out_ready;
         default: busy     = 1'b1;
      endcase
      accept = in_valid & in_ready;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               case (cls)
                  C_MUL:   state_nx = S_MUL;
                  C_DIV:   state_nx = S_DIV;
                  default: state_nx = S_DONE;
               endcase
            end else if (state == S_DONE && out_ready) begin
               state_nx = S_IDLE;
            end
         end
         S_MUL: if (mul_cnt == '0) state_nx = S_DONE;
`ifdef ALU_MC_DIV_EN
         S_DIV: if (dv_cnt == '0) state_nx = S_DONE;
`else
         S_DIV: state_nx = S_IDLE;
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   assign out_valid = (state == S_DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         result <= '0;
      end else begin
         state <= state_nx;
         if (accept && cls == C_ONE)
            result <= alu_out;
         else if (state == S_MUL && mul_cnt == '0)
            result <= mul_res;
`ifdef ALU_MC_DIV_EN
         else if (state == S_DIV && dv_cnt == '0)
            result <= dv_out;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         ma_q     <= ma_in;
         mb_q     <= mb_in;
         mul_hi_q <= (funct3 != 3'b000);
         mul_cnt  <= MUL_LOAD;
      end else if (state == S_MUL) begin
         mul_cnt <= mul_cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc: directed vectors, expected results queued at accept.
module tb_alu_mc;
   localparam int XLEN = 32;
   localparam int ML   = 2;
`ifdef ALU_MC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int DIV_LAT = DIV_EN ? XLEN + 1 : 1;
   localparam logic [6:0] LD = 7'b0000011, AI = 7'b0010011, AR = 7'b0110011;
   localparam logic [6:0] F0 = 7'b0000000, F1 = 7'b0000001, F20 = 7'b0100000;

   logic            clock, reset, in_valid, in_ready, out_valid, out_ready, busy;
   logic [6:0]      op, funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a, b, result;

   alu_mc #(.XLEN(XLEN), .MUL_LATENCY(ML)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];
   bit          mon_off = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dexp(input logic [31:0] v);
      return DIV_EN ? v : 32'h0;
   endfunction

   task automatic issue(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ex, input int lat, input bit push);
      int n;
      op = o; funct3 = f3; funct7 = f7; a = xa; b = xb; in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clock); #1; n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL %s accept: in_ready stuck at 0 expected 1", nm);
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         exp_q.push_back(ex);
         cyc_q.push_back(cyc + lat);
         name_q.push_back(nm);
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      op = 7'h7F; funct3 = 3'h7; funct7 = 7'h7F; a = 32'hDEADBEEF; b = 32'h0BADF00D;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clock); n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d results pending expected 0", exp_q.size());
         exp_q.delete(); cyc_q.delete(); name_q.delete();
      end
   endtask

   initial begin
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clock);
         #2;
         if (reset || mon_off) begin
            seen = 1'b0;
         end else begin
            if (out_valid && !seen) begin
               seen = 1'b1;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected out_valid: result %h expected none", result);
               end else begin
                  chk({name_q[0], " latency"}, 32'(cyc), 32'(cyc_q[0]));
               end
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() != 0) begin
                  chk(name_q[0], result, exp_q[0]);
                  void'(exp_q.pop_front());
                  void'(cyc_q.pop_front());
                  void'(name_q.pop_front());
               end
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; funct3 = '0; funct7 = '0; a = '0; b = '0;
      repeat (3) @(negedge clock);
      #1;
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset in_ready",  {31'b0, in_ready},  32'd1);
      chk("reset busy",      {31'b0, busy},      32'd0);
      chk("reset result",    result,             32'd0);
      reset = 1'b0;
      @(negedge clock);

      issue("add",   AR, 3'b000, F0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 1);
      issue("sub",   AR, 3'b000, F20, 32'd5,        32'd7,        32'hFFFFFFFE, 1, 1);
      issue("srai",  AI, 3'b101, F20, 32'h80000000, 32'h404,      32'hF8000000, 1, 1);
      issue("sltu",  AR, 3'b011, F0,  32'h1,        32'hFFFFFFFF, 32'h1,        1, 1);
      issue("slt",   AR, 3'b010, F0,  32'h1,        32'hFFFFFFFF, 32'h0,        1, 1);
      issue("slli",  AI, 3'b001, F0,  32'h1,        32'd31,       32'h80000000, 1, 1);
      issue("srl",   AR, 3'b101, F0,  32'h80000000, 32'h21,       32'h40000000, 1, 1);
      issue("xori",  AI, 3'b100, F0,  32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1, 1);
      issue("lw",    LD, 3'b010, F0,  32'h100,      32'hFFFFFFFC, 32'h000000FC, 1, 1);
      issue("badop", 7'h7F, 3'b000, F0, 32'h5,      32'h6,        32'h0,        1, 1);

      issue("mulh",  AR, 3'b001, F1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML, 1);
      chk("mul busy",     {31'b0, busy},     32'd1);
      chk("mul in_ready", {31'b0, in_ready}, 32'd0);
      issue("mulhu",  AR, 3'b011, F1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, 1);
      issue("mul",    AR, 3'b000, F1, 32'd7,        32'd6,        32'd42,       ML, 1);
      issue("mulhsu", AR, 3'b010, F1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, ML, 1);

      issue("div",    AR, 3'b100, F1, 32'hFFFFFFF9, 32'd2, dexp(32'hFFFFFFFD), DIV_LAT, 1);
      chk("div busy", {31'b0, busy}, {31'b0, DIV_EN});
      issue("rem",    AR, 3'b110, F1, 32'hFFFFFFF9, 32'd2, dexp(32'hFFFFFFFF), DIV_LAT, 1);
      issue("divu0",  AR, 3'b101, F1, 32'd10,       32'd0, dexp(32'hFFFFFFFF), DIV_LAT, 1);
      issue("remu0",  AR, 3'b111, F1, 32'd10,       32'd0, dexp(32'd10),       DIV_LAT, 1);
      issue("remov",  AR, 3'b110, F1, 32'h80000000, 32'hFFFFFFFF, 32'h0,      DIV_LAT, 1);
      issue("divov",  AR, 3'b100, F1, 32'h80000000, 32'hFFFFFFFF, dexp(32'h80000000), DIV_LAT, 1);
      issue("divu",   AR, 3'b101, F1, 32'd100,      32'd7, dexp(32'd14),       DIV_LAT, 1);
      drain();

      out_ready = 1'b0;
      issue("hold add", AR, 3'b000, F0, 32'd1, 32'd1, 32'd2, 1, 1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold out_valid", {31'b0, out_valid}, 32'd1);
         chk("hold result",    result,             32'd2);
         chk("hold in_ready",  {31'b0, in_ready},  32'd0);
         @(negedge clock);
      end
      out_ready = 1'b1;
      issue("b2b add", AR, 3'b000, F0, 32'd3, 32'd4, 32'd7, 1, 1);
      drain();

      out_ready = 1'b0;
      mon_off = 1'b1;
      issue("abort div", AR, 3'b100, F1, 32'd100, 32'd3, 32'd0, 1, 0);
      repeat (9) @(negedge clock);
      chk("abort busy before", {31'b0, busy}, {31'b0, DIV_EN});
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("abort out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort busy",      {31'b0, busy},      32'd0);
      chk("abort in_ready",  {31'b0, in_ready},  32'd1);
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      mon_off = 1'b0;
      issue("post add", AR, 3'b000, F0, 32'd2, 32'd3, 32'd5, 1, 1);
      drain();
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
